// File: rtl/route_compute_unit_if.sv
// ----------------------------------------------------------------------------
// route_compute_unit_if
//
// Bundles the per-VC head-flit decode handshake between the input-stage VC
// buffers (master) and the shared route compute engine (slave).
//
// Signals:
//   decodeHeadFlit   master->slave  VC bits       per-VC decode request (level)
//   HeadFlit         master->slave  VC*flit bits  per-VC head flit, VC v at slice v
//   RequestMessage   slave->master  VC*REQUEST_WIDTH  per-VC compacted output port
//   headFlitDecoded  slave->master  VC bits       per-VC result valid (level)
//   routeError       slave->master  VC bits       per-VC bad destination
//                                                 (present only with DEST_CHECK_EN)
// ----------------------------------------------------------------------------
interface route_compute_unit_if #(
    parameter int VC            = 4,
    parameter int PhitPerFlit   = 2,
    parameter int DATA_WIDTH    = 8,
    parameter int REQUEST_WIDTH = 3
);
    logic [VC-1:0]                          decodeHeadFlit;
    logic [VC*PhitPerFlit*DATA_WIDTH-1:0]   HeadFlit;
    logic [VC*REQUEST_WIDTH-1:0]            RequestMessage;
    logic [VC-1:0]                          headFlitDecoded;
`ifdef DEST_CHECK_EN
    logic [VC-1:0]                          routeError;

    modport master (
        output decodeHeadFlit, HeadFlit,
        input  RequestMessage, headFlitDecoded, routeError
    );
    modport slave (
        input  decodeHeadFlit, HeadFlit,
        output RequestMessage, headFlitDecoded, routeError
    );
`else
    modport master (
        output decodeHeadFlit, HeadFlit,
        input  RequestMessage, headFlitDecoded
    );
    modport slave (
        input  decodeHeadFlit, HeadFlit,
        output RequestMessage, headFlitDecoded
    );
`endif
endinterface

// File: rtl/route_compute_unit.sv
// ----------------------------------------------------------------------------
// route_compute_unit
//
// Shared, registered two-stage head-flit route computation for a mesh router
// input stage. A round-robin arbiter picks one requesting VC per cycle;
// stage 1 latches the VC id and destination, stage 2 computes the dimension-
// ordered direction (XY or YX) and writes the compacted output-port index
// (existing ports numbered in order L, E, N, W, S) back to that VC.
//
// Ports:
//   clk  clock
//   rst  asynchronous, active-low reset
//   bus  route_compute_unit_if.slave (decodeHeadFlit, HeadFlit in;
//        RequestMessage, headFlitDecoded, routeError out)
//
// Optional feature macro: DEST_CHECK_EN
//   Defined: destinations with DX >= DIM_X or DY >= DIM_Y report port 0 and
//   raise routeError for that VC; routeError is refreshed on every write.
//   Undefined: no range check; out-of-range coordinates are compared normally.
// ----------------------------------------------------------------------------
module route_compute_unit #(
    parameter int DIM_X         = 4,
    parameter int DIM_Y         = 4,
    parameter int INDEX         = 5,
    parameter int DATA_WIDTH    = 8,
    parameter int PhitPerFlit   = 2,
    parameter int VC            = 4,
    parameter int COORD_W       = 4,
    parameter int REQUEST_WIDTH = 3,
    parameter int ROUTING       = 0
) (
    input logic                 clk,
    input logic                 rst,
    route_compute_unit_if.slave bus
);
    localparam int FLIT_W = PhitPerFlit * DATA_WIDTH;
    localparam int VC_W   = (VC > 1) ? $clog2(VC) : 1;
    localparam int NODE_X = INDEX % DIM_X;
    localparam int NODE_Y = INDEX / DIM_X;

    // Which of this node's mesh ports physically exist.
    localparam int HAS_E = (NODE_X < DIM_X - 1) ? 1 : 0;
    localparam int HAS_N = (NODE_Y < DIM_Y - 1) ? 1 : 0;
    localparam int HAS_W = (NODE_X > 0) ? 1 : 0;
    localparam int HAS_S = (NODE_Y > 0) ? 1 : 0;

    // Compacted indices: each port's number is the count of existing ports
    // that precede it in L, E, N, W, S order.
    localparam logic [REQUEST_WIDTH-1:0] PORT_L = '0;
    localparam logic [REQUEST_WIDTH-1:0] PORT_E = REQUEST_WIDTH'(1);
    localparam logic [REQUEST_WIDTH-1:0] PORT_N = REQUEST_WIDTH'(1 + HAS_E);
    localparam logic [REQUEST_WIDTH-1:0] PORT_W = REQUEST_WIDTH'(1 + HAS_E + HAS_N);
    localparam logic [REQUEST_WIDTH-1:0] PORT_S = REQUEST_WIDTH'(1 + HAS_E + HAS_N + HAS_W);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} vcState_t;
    typedef enum logic [2:0] {DIR_L, DIR_E, DIR_N, DIR_W, DIR_S} dir_t;

    logic [COORD_W-1:0]       vcDx [VC];
    logic [COORD_W-1:0]       vcDy [VC];
    logic [VC-1:0]            eligible;

    logic                     grantValid;
    logic [VC_W-1:0]          grantVc;
    logic [VC_W-1:0]          rrPtrReg;

    logic                     s1ValidReg;
    logic [VC_W-1:0]          s1VcReg;
    logic [COORD_W-1:0]       s1DxReg;
    logic [COORD_W-1:0]       s1DyReg;

    dir_t                     routeDir;
    logic [REQUEST_WIDTH-1:0] routePort;
    logic [REQUEST_WIDTH-1:0] routeResult;

    // Only the two coordinate fields of each flit matter here; the rest is
    // payload passing through the VC buffers.
    logic unusedFlitBits;
    assign unusedFlitBits = ^bus.HeadFlit;

    // ------------------------------------------------------------------
    // Round-robin arbiter: first eligible VC at or after the pointer.
    // ------------------------------------------------------------------
    always_comb begin
        grantValid = 1'b0;
        grantVc    = '0;
        for (int i = 0; i < VC; i++) begin
            if (!grantValid && eligible[(int'(rrPtrReg) + i) % VC]) begin
                grantValid = 1'b1;
                grantVc    = VC_W'((int'(rrPtrReg) + i) % VC);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rrPtrReg <= '0;
        end else if (grantValid) begin
            rrPtrReg <= (int'(grantVc) == VC - 1) ? '0 : grantVc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture the granted VC and its destination.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1ValidReg <= 1'b0;
            s1VcReg    <= '0;
            s1DxReg    <= '0;
            s1DyReg    <= '0;
        end else begin
            s1ValidReg <= grantValid;
            if (grantValid) begin
                s1VcReg <= grantVc;
                s1DxReg <= vcDx[grantVc];
                s1DyReg <= vcDy[grantVc];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 datapath: dimension-ordered direction, then compaction.
    // ------------------------------------------------------------------
    always_comb begin
        routeDir = DIR_L;
        if (ROUTING == 0) begin
            if (int'(s1DxReg) != NODE_X)
                routeDir = (int'(s1DxReg) > NODE_X) ? DIR_E : DIR_W;
            else if (int'(s1DyReg) != NODE_Y)
                routeDir = (int'(s1DyReg) > NODE_Y) ? DIR_N : DIR_S;
        end else begin
            if (int'(s1DyReg) != NODE_Y)
                routeDir = (int'(s1DyReg) > NODE_Y) ? DIR_N : DIR_S;
            else if (int'(s1DxReg) != NODE_X)
                routeDir = (int'(s1DxReg) > NODE_X) ? DIR_E : DIR_W;
        end
    end

    // A direction pointing off the mesh edge collapses to port 0.
    always_comb begin
        routePort = PORT_L;
        case (routeDir)
            DIR_E:   routePort = (HAS_E != 0) ? PORT_E : PORT_L;
            DIR_N:   routePort = (HAS_N != 0) ? PORT_N : PORT_L;
            DIR_W:   routePort = (HAS_W != 0) ? PORT_W : PORT_L;
            DIR_S:   routePort = (HAS_S != 0) ? PORT_S : PORT_L;
            default: routePort = PORT_L;
        endcase
    end

`ifdef DEST_CHECK_EN
    logic rangeErr;
    assign rangeErr    = (int'(s1DxReg) >= DIM_X) || (int'(s1DyReg) >= DIM_Y);
    assign routeResult = rangeErr ? PORT_L : routePort;
`else
    assign routeResult = routePort;
`endif

    // ------------------------------------------------------------------
    // Per-VC control and result registers.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < VC; gi++) begin : gVc
        vcState_t                 stateReg;
        vcState_t                 stateNext;
        logic                     reqLevel;
        logic                     granted;
        logic                     s2Hit;
        logic                     isIdle;
        logic                     writeEn;
        logic                     clearEn;
        logic [REQUEST_WIDTH-1:0] reqMsgReg;
        logic                     decodedReg;

        assign vcDx[gi]     = bus.HeadFlit[gi*FLIT_W + COORD_W +: COORD_W];
        assign vcDy[gi]     = bus.HeadFlit[gi*FLIT_W +: COORD_W];
        assign reqLevel     = bus.decodeHeadFlit[gi];
        assign granted      = grantValid && (int'(grantVc) == gi);
        assign s2Hit        = s1ValidReg && (int'(s1VcReg) == gi);
        assign eligible[gi] = reqLevel && isIdle;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) stateReg <= IDLE;
            else      stateReg <= stateNext;
        end

        // A dropped request at the stage-2 edge cancels the decode; a
        // finished VC waits for its request to fall before re-arming.
        always_comb begin
            stateNext = stateReg;
            case (stateReg)
                IDLE:    if (granted) stateNext = BUSY;
                BUSY:    if (s2Hit) stateNext = reqLevel ? DONE : IDLE;
                DONE:    if (!reqLevel) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end

        always_comb begin
            isIdle  = (stateReg == IDLE);
            writeEn = (stateReg == BUSY) && s2Hit && reqLevel;
            clearEn = (stateReg == DONE) && !reqLevel;
        end

        // RequestMessage holds until the next successful write for this VC.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                reqMsgReg  <= '0;
                decodedReg <= 1'b0;
            end else if (writeEn) begin
                reqMsgReg  <= routeResult;
                decodedReg <= 1'b1;
            end else if (clearEn) begin
                decodedReg <= 1'b0;
            end
        end

        assign bus.RequestMessage[gi*REQUEST_WIDTH +: REQUEST_WIDTH] = reqMsgReg;
        assign bus.headFlitDecoded[gi] = decodedReg;

`ifdef DEST_CHECK_EN
        logic routeErrorReg;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)         routeErrorReg <= 1'b0;
            else if (writeEn) routeErrorReg <= rangeErr;
        end
        assign bus.routeError[gi] = routeErrorReg;
`endif
    end
endmodule

// File: tb/tb_route_compute_unit.sv
// ----------------------------------------------------------------------------
// tb_route_compute_unit
//
// Four instances share one stimulus stream: 4x4 node 5 XY, 4x4 node 5 YX,
// 4x4 node 0 XY and 3x5 node 14 XY. A behavioural model (request bookkeeping
// plus a port-list route function) predicts every output each cycle; directed
// vectors add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_route_compute_unit;
    localparam int VC   = 4;
    localparam int PPF  = 2;
    localparam int DW   = 8;
    localparam int RW   = 3;
    localparam int CW   = 4;
    localparam int FW   = PPF * DW;
    localparam int NCFG = 4;
    localparam int NVEC = 10;

    localparam int CFG_DIMX [NCFG] = '{4, 4, 4, 3};
    localparam int CFG_DIMY [NCFG] = '{4, 4, 4, 5};
    localparam int CFG_IDX  [NCFG] = '{5, 5, 0, 14};
    localparam int CFG_YX   [NCFG] = '{0, 1, 0, 0};

    // Directed destinations and hand-derived ports (main, yx, corner, mesh35).
    // Node 14 of the 3x5 mesh is (2,4): only L, W, S exist, so W=1 and S=2.
    localparam int VEC_DX [NVEC] = '{3, 1, 1, 0, 2, 0, 0, 2, 7, 1};
    localparam int VEC_DY [NVEC] = '{1, 3, 1, 0, 2, 3, 4, 0, 0, 3};
    localparam int VEC_EXP [NVEC][NCFG] = '{
        '{1, 1, 1, 0},
        '{2, 2, 1, 1},
        '{0, 0, 1, 1},
        '{3, 4, 0, 1},
        '{1, 2, 1, 2},
        '{3, 2, 2, 1},
        '{3, 2, 2, 1},
        '{1, 4, 1, 2},
        '{1, 4, 1, 0},
        '{2, 2, 1, 1}
    };

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [VC-1:0]    req;
    logic [VC*FW-1:0] flitBus;

    route_compute_unit_if #(.VC(VC), .PhitPerFlit(PPF), .DATA_WIDTH(DW), .REQUEST_WIDTH(RW))
        ifMain(), ifYx(), ifCorner(), ifMesh();

    assign ifMain.decodeHeadFlit   = req;
    assign ifMain.HeadFlit         = flitBus;
    assign ifYx.decodeHeadFlit     = req;
    assign ifYx.HeadFlit           = flitBus;
    assign ifCorner.decodeHeadFlit = req;
    assign ifCorner.HeadFlit       = flitBus;
    assign ifMesh.decodeHeadFlit   = req;
    assign ifMesh.HeadFlit         = flitBus;

    route_compute_unit #(.DIM_X(4), .DIM_Y(4), .INDEX(5), .ROUTING(0))
        dutMain (.clk(clk), .rst(rst), .bus(ifMain));
    route_compute_unit #(.DIM_X(4), .DIM_Y(4), .INDEX(5), .ROUTING(1))
        dutYx (.clk(clk), .rst(rst), .bus(ifYx));
    route_compute_unit #(.DIM_X(4), .DIM_Y(4), .INDEX(0), .ROUTING(0))
        dutCorner (.clk(clk), .rst(rst), .bus(ifCorner));
    route_compute_unit #(.DIM_X(3), .DIM_Y(5), .INDEX(14), .ROUTING(0))
        dutMesh (.clk(clk), .rst(rst), .bus(ifMesh));

    logic [VC*RW-1:0] gotMsg [NCFG];
    logic [VC-1:0]    gotDec [NCFG];
    assign gotMsg[0] = ifMain.RequestMessage;
    assign gotMsg[1] = ifYx.RequestMessage;
    assign gotMsg[2] = ifCorner.RequestMessage;
    assign gotMsg[3] = ifMesh.RequestMessage;
    assign gotDec[0] = ifMain.headFlitDecoded;
    assign gotDec[1] = ifYx.headFlitDecoded;
    assign gotDec[2] = ifCorner.headFlitDecoded;
    assign gotDec[3] = ifMesh.headFlitDecoded;
`ifdef DEST_CHECK_EN
    logic [VC-1:0] gotErr [NCFG];
    assign gotErr[0] = ifMain.routeError;
    assign gotErr[1] = ifYx.routeError;
    assign gotErr[2] = ifCorner.routeError;
    assign gotErr[3] = ifMesh.routeError;

    function automatic bit inRange(int cfg, int dx, int dy);
        return (dx < CFG_DIMX[cfg]) && (dy < CFG_DIMY[cfg]);
    endfunction
`endif

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Route from the rules: pick the direction, then find its position in the
    // list of ports that exist at this node.
    function automatic int modelRoute(int cfg, int dx, int dy);
        int  dimX = CFG_DIMX[cfg];
        int  dimY = CFG_DIMY[cfg];
        int  x    = CFG_IDX[cfg] % dimX;
        int  y    = CFG_IDX[cfg] / dimX;
        int  dir;                 // 0 L, 1 E, 2 N, 3 W, 4 S
        int  pos;
        bit  exists [5];
`ifdef DEST_CHECK_EN
        if (dx >= dimX || dy >= dimY) return 0;
`endif
        if (CFG_YX[cfg] != 0) begin
            if (dy != y)      dir = (dy > y) ? 2 : 4;
            else if (dx != x) dir = (dx > x) ? 1 : 3;
            else              dir = 0;
        end else begin
            if (dx != x)      dir = (dx > x) ? 1 : 3;
            else if (dy != y) dir = (dy > y) ? 2 : 4;
            else              dir = 0;
        end
        exists = '{1'b1, x < dimX - 1, y < dimY - 1, x > 0, y > 0};
        if (!exists[dir]) return 0;
        pos = 0;
        for (int d = 0; d < dir; d++) if (exists[d]) pos++;
        return pos;
    endfunction

    function automatic int litExp(int cfg, int i);
`ifdef DEST_CHECK_EN
        if (!inRange(cfg, VEC_DX[i], VEC_DY[i])) return 0;
`endif
        return VEC_EXP[i][cfg];
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    bit expDec [VC];
    bit owned  [VC];             // request taken by the engine, not yet re-armed
    int expMsg [NCFG][VC];
`ifdef DEST_CHECK_EN
    bit expErr [NCFG][VC];
`endif
    int pend = -1;
    int pendDx = 0;
    int pendDy = 0;
    int ptr = 0;

    initial begin : model
        int g;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                pend = -1;
                ptr  = 0;
                for (int v = 0; v < VC; v++) begin
                    expDec[v] = 1'b0;
                    owned[v]  = 1'b0;
                    for (int c = 0; c < NCFG; c++) begin
                        expMsg[c][v] = 0;
`ifdef DEST_CHECK_EN
                        expErr[c][v] = 1'b0;
`endif
                    end
                end
            end else begin
                g = -1;
                for (int i = 0; i < VC; i++)
                    if (g < 0 && req[(ptr + i) % VC] && !owned[(ptr + i) % VC])
                        g = (ptr + i) % VC;
                for (int v = 0; v < VC; v++)
                    if (expDec[v] && !req[v]) begin
                        expDec[v] = 1'b0;
                        owned[v]  = 1'b0;
                    end
                if (pend >= 0) begin
                    if (req[pend]) begin
                        expDec[pend] = 1'b1;
                        for (int c = 0; c < NCFG; c++) begin
                            expMsg[c][pend] = modelRoute(c, pendDx, pendDy);
`ifdef DEST_CHECK_EN
                            expErr[c][pend] = !inRange(c, pendDx, pendDy);
`endif
                        end
                    end else begin
                        owned[pend] = 1'b0;
                    end
                end
                pend = g;
                if (g >= 0) begin
                    owned[g] = 1'b1;
                    ptr      = (g + 1) % VC;
                    pendDx   = int'(flitBus[g*FW + CW +: CW]);
                    pendDy   = int'(flitBus[g*FW +: CW]);
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            for (int c = 0; c < NCFG; c++)
                for (int v = 0; v < VC; v++) begin
                    check($sformatf("cfg%0d vc%0d decoded", c, v),
                          32'(gotDec[c][v]), 32'(expDec[v]));
                    check($sformatf("cfg%0d vc%0d msg", c, v),
                          32'(gotMsg[c][v*RW +: RW]), 32'(expMsg[c][v]));
`ifdef DEST_CHECK_EN
                    check($sformatf("cfg%0d vc%0d err", c, v),
                          32'(gotErr[c][v]), 32'(expErr[c][v]));
`endif
                end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setVc(int v, int dx, int dy);
        flitBus[v*FW +: FW] = {8'hA5, 4'(dx), 4'(dy)};
        req[v] = 1'b1;
    endtask

    task automatic checkAllZero(string tag);
        for (int c = 0; c < NCFG; c++) begin
            check($sformatf("%s cfg%0d decoded", tag, c), 32'(gotDec[c]), 32'd0);
            check($sformatf("%s cfg%0d msg", tag, c), 32'(gotMsg[c]), 32'd0);
`ifdef DEST_CHECK_EN
            check($sformatf("%s cfg%0d err", tag, c), 32'(gotErr[c]), 32'd0);
`endif
        end
    endtask

    initial begin : stim
        req     = '0;
        flitBus = '0;
        rst     = 1'b0;
        tick(2);
        checkAllZero("reset");
        rst = 1'b1;
        tick(1);

        // Single-VC vectors on VC0 across all four node configurations.
        for (int i = 0; i < NVEC; i++) begin
            setVc(0, VEC_DX[i], VEC_DY[i]);
            tick(1);
            check($sformatf("vec%0d early decoded", i), 32'(gotDec[0][0]), 32'd0);
            tick(1);
            for (int c = 0; c < NCFG; c++) begin
                check($sformatf("vec%0d cfg%0d decoded", i, c), 32'(gotDec[c][0]), 32'd1);
                check($sformatf("vec%0d cfg%0d msg", i, c), 32'(gotMsg[c][RW-1:0]), 32'(litExp(c, i)));
`ifdef DEST_CHECK_EN
                check($sformatf("vec%0d cfg%0d err", i, c), 32'(gotErr[c][0]),
                      32'(!inRange(c, VEC_DX[i], VEC_DY[i])));
`endif
            end
            $display("vec %0d dest (%0d,%0d) msg main=%0d yx=%0d corner=%0d mesh=%0d",
                     i, VEC_DX[i], VEC_DY[i], gotMsg[0][RW-1:0], gotMsg[1][RW-1:0],
                     gotMsg[2][RW-1:0], gotMsg[3][RW-1:0]);
            req[0] = 1'b0;
            tick(1);
            check($sformatf("vec%0d release decoded", i), 32'(gotDec[0][0]), 32'd0);
        end

        // Reset returns the RR pointer to 0, then all four VCs contend.
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        setVc(0, 3, 1);
        setVc(1, 1, 3);
        setVc(2, 0, 0);
        setVc(3, 1, 1);
        tick(2);
        check("rr step0", 32'(gotDec[0]), 32'h1);
        tick(1);
        check("rr step1", 32'(gotDec[0]), 32'h3);
        tick(1);
        check("rr step2", 32'(gotDec[0]), 32'h7);
        tick(1);
        check("rr step3", 32'(gotDec[0]), 32'hF);
        check("rr msgs", 32'(gotMsg[0]), 32'({3'd0, 3'd3, 3'd2, 3'd1}));
        $display("contention: all four VCs decoded msg=%h", gotMsg[0]);
        req[2] = 1'b0;
        tick(1);
        check("drop vc2 decoded", 32'(gotDec[0]), 32'hB);
        check("drop vc2 msg held", 32'(gotMsg[0][2*RW +: RW]), 32'd3);
        $display("contention: VC2 released");
        req = '0;
        tick(2);

        // Cancel VC1 while it sits in stage 1.
        setVc(1, 3, 1);
        tick(1);
        req[1] = 1'b0;
        tick(1);
        check("cancel decoded", 32'(gotDec[0][1]), 32'd0);
        check("cancel msg held", 32'(gotMsg[0][RW +: RW]), 32'd2);
        tick(2);
        check("cancel decoded later", 32'(gotDec[0][1]), 32'd0);
        $display("cancel: VC1 dropped after grant");
        setVc(1, 0, 0);
        tick(2);
        check("after cancel decoded", 32'(gotDec[0][1]), 32'd1);
        check("after cancel msg", 32'(gotMsg[0][RW +: RW]), 32'd3);
        req[1] = 1'b0;
        tick(1);

        // Asynchronous reset with one result out and one decode in flight.
        setVc(2, 3, 1);
        tick(2);
        check("pre-reset vc2 decoded", 32'(gotDec[0][2]), 32'd1);
        setVc(0, 1, 3);
        tick(1);
        #2;
        rst = 1'b0;
        #1;
        checkAllZero("async reset");
        $display("async reset mid-pipeline");
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(3);
        check("post-reset decoded", 32'(gotDec[0]), 32'h5);
        check("post-reset msg0", 32'(gotMsg[0][RW-1:0]), 32'd2);
        check("post-reset msg2", 32'(gotMsg[0][2*RW +: RW]), 32'd1);
        req = '0;
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
